// File: rtl/jk_drive_ctrl.sv
// jk_drive_ctrl
//   Driver-side controller for a JK flip-flop. A target Q value is taken over a
//   valid/ready handshake. J/K are derived from the excitation table using the
//   flop's fed-back Q at the moment of acceptance. The drive is held for one
//   clock, then the controller waits a settle time and checks the flop output.
//
//   Build option: define JK_ERR_CNT_EN to add the saturating err_cnt output.
//
// Parameters
//   SETTLE_CYC  clocks waited after the drive cycle before Q is checked (>=1)
//   USE_TOGGLE  1: a required change is driven as J=K=1, 0: as set/reset
//   ERR_W       width of err_cnt (only with JK_ERR_CNT_EN)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   tgt_valid  target bit offered
//   tgt_bit    desired next Q
//   tgt_ready  controller can accept a target
//   j, k       drive to the flop, asserted only during the drive cycle
//   q_fb       flop Q feedback (same clock domain)
//   busy       transaction in progress
//   done       one-cycle pulse when the check completes
//   err        one-cycle pulse with done when q_fb differs from the target
//   err_cnt    saturating mismatch count (only with JK_ERR_CNT_EN)
module jk_drive_ctrl #(
   parameter int SETTLE_CYC = 1,
   parameter bit USE_TOGGLE = 1'b0
`ifdef JK_ERR_CNT_EN
   ,
   parameter int ERR_W      = 8
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tgt_valid,
   input  logic             tgt_bit,
   output logic             tgt_ready,
   output logic             j,
   output logic             k,
   input  logic             q_fb,
   output logic             busy,
   output logic             done,
   output logic             err
`ifdef JK_ERR_CNT_EN
   ,
   output logic [ERR_W-1:0] err_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   state_t           state;
   logic             tgt_q;
   logic [CNT_W-1:0] cnt;

   // Latched target is data only; it is meaningful solely while busy.
   always_ff @(posedge clk) begin
      if (state == IDLE && tgt_valid && tgt_ready)
         tgt_q <= tgt_bit;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         tgt_ready <= 1'b0;
         j         <= 1'b0;
         k         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         // Pulsed outputs default low every cycle.
         done <= 1'b0;
         err  <= 1'b0;
         j    <= 1'b0;
         k    <= 1'b0;
         case (state)
            IDLE: begin
               tgt_ready <= 1'b1;
               if (tgt_valid && tgt_ready) begin
                  state     <= DRIVE;
                  busy      <= 1'b1;
                  tgt_ready <= 1'b0;
                  // An unknown q_fb makes both tests false, so the drive stays 00.
                  if (tgt_bit && !q_fb) begin
                     j <= 1'b1;
                     k <= USE_TOGGLE;
                  end else if (!tgt_bit && q_fb) begin
                     j <= USE_TOGGLE;
                     k <= 1'b1;
                  end
               end
            end
            DRIVE: begin
               // The flop captures J/K on the edge that leaves this state.
               state <= SETTLE;
               cnt   <= CNT_W'(SETTLE_CYC - 1);
            end
            SETTLE: begin
               if (cnt == '0) begin
                  state <= CHECK;
                  done  <= 1'b1;
                  // Written as a match test so an unknown q_fb reports an error.
                  if (q_fb == tgt_q)
                     err <= 1'b0;
                  else
                     err <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            CHECK: begin
               state     <= IDLE;
               busy      <= 1'b0;
               tgt_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef JK_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err_cnt <= '0;
      else if (err && (err_cnt != {ERR_W{1'b1}}))
         err_cnt <= err_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_jk_drive_ctrl.sv
// tb_jk_drive_ctrl
//   Bench for jk_drive_ctrl. Lane 0 uses set/reset drive, lane 1 uses toggle
//   drive; each lane has its own behavioural JK flop (lane 0 can be forced
//   stuck at 0). Stimulus pushes hand-computed expectations into a per-lane
//   queue; a per-lane monitor pops and compares whenever done is seen.
module tb_jk_drive_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] tv, tbit, stuck;
   logic [1:0] trdy, jv, kv, busy;
   int         checks = 0;
   int         errors = 0;

   typedef struct packed {
      logic [1:0] jk;
      logic       e;
      logic       qa;
   } exp_t;

   always #5 clk = ~clk;

   task automatic chk(input int lane, input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL lane%0d %s actual=%0h required=%0h", lane, name, act, req);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      logic       q;
      logic       done;
      logic       err;
`ifdef JK_ERR_CNT_EN
      logic [1:0] err_cnt;
`endif
      exp_t       sb[$];
      exp_t       e;
      logic       busy_prev = 1'b0;
      logic       drv_seen  = 1'b0;
      logic [1:0] jk_seen   = 2'b00;

      jk_drive_ctrl #(
         .SETTLE_CYC(1),
         .USE_TOGGLE((g == 1) ? 1'b1 : 1'b0)
`ifdef JK_ERR_CNT_EN
         ,
         .ERR_W(2)
`endif
      ) dut (
         .clk(clk),
         .rst(rst),
         .tgt_valid(tv[g]),
         .tgt_bit(tbit[g]),
         .tgt_ready(trdy[g]),
         .j(jv[g]),
         .k(kv[g]),
         .q_fb(q),
         .busy(busy[g]),
         .done(done),
         .err(err)
`ifdef JK_ERR_CNT_EN
         ,
         .err_cnt(err_cnt)
`endif
      );

      // Behavioural JK flop, optionally stuck at 0.
      always @(posedge clk or negedge rst) begin
         if (!rst) q <= 1'b0;
         else if (stuck[g]) q <= 1'b0;
         else begin
            case ({jv[g], kv[g]})
               2'b01:   q <= 1'b0;
               2'b10:   q <= 1'b1;
               2'b11:   q <= ~q;
               default: q <= q;
            endcase
         end
      end

      always @(negedge clk) begin
         if (!rst) begin
            busy_prev = 1'b0;
            drv_seen  = 1'b0;
         end else begin
            if (busy[g] && !busy_prev) begin
               jk_seen  = {jv[g], kv[g]};
               drv_seen = 1'b1;
            end else begin
               chk(g, "jk_outside_drive", {6'b0, jv[g], kv[g]}, 8'h00);
            end
            if (done) begin
               if (sb.size() == 0) begin
                  chk(g, "unexpected_done", 8'h01, 8'h00);
               end else begin
                  e = sb.pop_front();
                  chk(g, "drive_seen", {7'b0, drv_seen}, 8'h01);
                  chk(g, "drive_jk", {6'b0, jk_seen}, {6'b0, e.jk});
                  chk(g, "check_err", {7'b0, err}, {7'b0, e.e});
                  chk(g, "q_after", {7'b0, q}, {7'b0, e.qa});
               end
               drv_seen = 1'b0;
            end else begin
               chk(g, "err_without_done", {7'b0, err}, 8'h00);
            end
            busy_prev = busy[g];
         end
      end
   end

   task automatic push(input int d, input exp_t x);
      if (d == 0) lane[0].sb.push_back(x);
      else        lane[1].sb.push_back(x);
   endtask

   task automatic send(input int d, input logic t, input logic [1:0] jk, input logic e, input logic qa);
      exp_t x;
      int   n;
      n = 0;
      @(negedge clk);
      while (!trdy[d] && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(d, "ready_wait", {7'b0, trdy[d]}, 8'h01);
      x.jk = jk;
      x.e  = e;
      x.qa = qa;
      push(d, x);
      tv[d]   = 1'b1;
      tbit[d] = t;
      @(negedge clk);
      tv[d]   = 1'b0;
      tbit[d] = ~t;
   endtask

   task automatic wait_idle(input int d);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy[d] || !trdy[d]) && n < 100);
      chk(d, "idle_reached", {7'b0, (busy[d] || !trdy[d])}, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] pat;
      int          acc;

      rst   = 1'b0;
      tv    = 2'b00;
      tbit  = 2'b00;
      stuck = 2'b00;

      // Reset state
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk(d, "rst_jk", {6'b0, jv[d], kv[d]}, 8'h00);
         chk(d, "rst_busy", {7'b0, busy[d]}, 8'h00);
         chk(d, "rst_ready", {7'b0, trdy[d]}, 8'h00);
      end
      rst = 1'b1;
      #1;
      chk(0, "ready_before_edge", {7'b0, trdy[0]}, 8'h00);
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++)
         chk(d, "ready_after_release", {7'b0, trdy[d]}, 8'h01);

      // Set/reset drive, Q starts at 0: targets 1,0,0,1
      send(0, 1'b1, 2'b10, 1'b0, 1'b1);
      send(0, 1'b0, 2'b01, 1'b0, 1'b0);
      send(0, 1'b0, 2'b00, 1'b0, 1'b0);
      send(0, 1'b1, 2'b10, 1'b0, 1'b1);
      wait_idle(0);
      chk(0, "q_end_directed", {7'b0, lane[0].q}, 8'h01);

      // Stuck-at-0 flop: every target 1 drives 10 and reports err
      stuck[0] = 1'b1;
      send(0, 1'b1, 2'b10, 1'b1, 1'b0);
      wait_idle(0);
`ifdef JK_ERR_CNT_EN
      chk(0, "err_cnt_one", {6'b0, lane[0].err_cnt}, 8'h01);
`endif
      repeat (4) send(0, 1'b1, 2'b10, 1'b1, 1'b0);
      wait_idle(0);
`ifdef JK_ERR_CNT_EN
      chk(0, "err_cnt_saturated", {6'b0, lane[0].err_cnt}, 8'h03);
`endif
      stuck[0] = 1'b0;

      // Backpressure: valid held, bit changes every cycle; accepts at 0,4,8,12
      pat = 16'b1001_1001_1010_0101;
      push(0, '{jk: 2'b10, e: 1'b0, qa: 1'b1});
      push(0, '{jk: 2'b01, e: 1'b0, qa: 1'b0});
      push(0, '{jk: 2'b10, e: 1'b0, qa: 1'b1});
      push(0, '{jk: 2'b00, e: 1'b0, qa: 1'b1});
      acc = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         tv[0]   = 1'b1;
         tbit[0] = pat[i];
         if (trdy[0]) acc++;
      end
      @(negedge clk);
      tv[0] = 1'b0;
      wait_idle(0);
      chk(0, "accept_count", 8'(acc), 8'h04);
      chk(0, "q_end_backpressure", {7'b0, lane[0].q}, 8'h01);

      // Reset during the drive cycle aborts the transaction
      @(negedge clk);
      tv[0]   = 1'b1;
      tbit[0] = 1'b0;
      @(posedge clk);
      #1;
      tv[0] = 1'b0;
      chk(0, "abort_drive_jk", {6'b0, jv[0], kv[0]}, 8'h01);
      rst = 1'b0;
      #1;
      chk(0, "abort_jk", {6'b0, jv[0], kv[0]}, 8'h00);
      chk(0, "abort_busy", {7'b0, busy[0]}, 8'h00);
      chk(0, "abort_done", {7'b0, lane[0].done}, 8'h00);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk(0, "no_done_after_abort", {7'b0, lane[0].done}, 8'h00);
      end
      send(0, 1'b1, 2'b10, 1'b0, 1'b1);
      wait_idle(0);

      // Toggle drive, Q starts at 0: targets 1,0
      send(1, 1'b1, 2'b11, 1'b0, 1'b1);
      send(1, 1'b0, 2'b11, 1'b0, 1'b0);
      wait_idle(1);

      chk(0, "queue_empty", 8'(lane[0].sb.size()), 8'h00);
      chk(1, "queue_empty", 8'(lane[1].sb.size()), 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
